// File: rtl/wr_budget_pkg.sv
// Shared types and constants for the write-budget tracker.
// Holds the slot state enum, default widths and the helper
// that sizes each slot's outstanding-transaction counter.
package wr_budget_pkg;

    typedef enum logic [1:0] {
        SLOT_FREE    = 2'd0,
        SLOT_BUSY    = 2'd1,
        SLOT_EXPIRED = 2'd2
    } slot_state_e;

    localparam int unsigned DefNumSlots    = 4;
    localparam int unsigned DefIdWidth     = 4;
    localparam int unsigned DefBudgetWidth = 8;
    localparam int unsigned DefMaxTxnPerId = 4;
    localparam int unsigned StatWidth      = 16;

    // Counter must hold 0..max_txn inclusive.
    function automatic int unsigned txn_cnt_width(input int unsigned max_txn);
        return $clog2(max_txn + 1);
    endfunction

endpackage

// File: rtl/wr_budget_slot.sv
// One tracker slot: state, tracked ID, outstanding count and budget countdown.
// Ports:
//   clk_i, rst_i      clock, async active-high reset
//   alloc_i           claim this FREE slot for id_i with budget_i
//   inc_i / dec_i     matching AW / matching B handshake this cycle
//   id_i, budget_i    allocation ID, allocation/reload budget
//   state_o           registered slot state
//   id_o, num_txn_o   registered tracked ID and outstanding count
//   expire_c_o        combinational: slot goes BUSY->EXPIRED at this edge
module wr_budget_slot
    import wr_budget_pkg::*;
#(
    parameter int unsigned IdWidth     = DefIdWidth,
    parameter int unsigned BudgetWidth = DefBudgetWidth,
    parameter int unsigned MaxTxnPerId = DefMaxTxnPerId,
    parameter bit          ReloadOnB   = 1'b1,
    localparam int unsigned CntWidth   = txn_cnt_width(MaxTxnPerId)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   alloc_i,
    input  logic                   inc_i,
    input  logic                   dec_i,
    input  logic [IdWidth-1:0]     id_i,
    input  logic [BudgetWidth-1:0] budget_i,
    output slot_state_e            state_o,
    output logic [IdWidth-1:0]     id_o,
    output logic [CntWidth-1:0]    num_txn_o,
    output logic                   expire_c_o
);

    slot_state_e            state_q, state_d;
    logic [IdWidth-1:0]     id_q, id_d;
    logic [CntWidth-1:0]    cnt_q, cnt_d, cnt_nxt;
    logic [BudgetWidth-1:0] budget_q, budget_d;
    logic                   expire_c;

    // Next-state: allocation, count update, reload or countdown/expiry.
    always_comb begin
        state_d  = state_q;
        id_d     = id_q;
        cnt_d    = cnt_q;
        budget_d = budget_q;
        expire_c = 1'b0;
        // Same-cycle inc and dec cancel, so the slot is never freed and re-allocated.
        cnt_nxt  = cnt_q + CntWidth'(inc_i) - CntWidth'(dec_i);
        case (state_q)
            SLOT_FREE: begin
                if (alloc_i) begin
                    state_d  = SLOT_BUSY;
                    id_d     = id_i;
                    cnt_d    = CntWidth'(1);
                    budget_d = budget_i;
                end
            end
            SLOT_BUSY, SLOT_EXPIRED: begin
                cnt_d = cnt_nxt;
                if (cnt_nxt == '0) begin
                    state_d  = SLOT_FREE;
                    id_d     = '0;
                    budget_d = '0;
                end else if (dec_i && ReloadOnB) begin
                    state_d  = SLOT_BUSY;
                    budget_d = budget_i;
                end else if (state_q == SLOT_BUSY) begin
                    if (budget_q != '0) begin
                        budget_d = budget_q - BudgetWidth'(1);
                    end else if (!dec_i) begin
                        // A matching B this cycle defers expiry.
                        state_d  = SLOT_EXPIRED;
                        expire_c = 1'b1;
                    end
                end
            end
            default: state_d = SLOT_FREE;
        endcase
    end

    // State registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= SLOT_FREE;
            id_q     <= '0;
            cnt_q    <= '0;
            budget_q <= '0;
        end else begin
            state_q  <= state_d;
            id_q     <= id_d;
            cnt_q    <= cnt_d;
            budget_q <= budget_d;
        end
    end

    assign state_o    = state_q;
    assign id_o       = id_q;
    assign num_txn_o  = cnt_q;
    assign expire_c_o = expire_c;

endmodule

// File: rtl/wr_budget_tracker.sv
// Multi-slot AXI write-transaction watchdog. Observes AW/B handshakes,
// tracks outstanding writes per ID and flags budget timeouts and anomalies.
// Optional statistics counters are built when WR_BUDGET_STATS_EN is defined;
// otherwise stat_done_o/stat_tout_o are tied to zero.
// Ports:
//   clk_i, rst_i                 clock, async active-high reset
//   budget_i                     budget loaded on allocation / reload
//   aw_valid_i/aw_ready_i/aw_id_i observed AW handshake
//   b_valid_i/b_ready_i/b_id_i    observed B handshake
//   clr_i                        clears sticky flags (a coincident set wins)
//   accept_o                     combinational: an AW with aw_id_i would be tracked
//   slot_busy_o, timeout_o       per-slot non-FREE / EXPIRED levels
//   timeout_irq_o, overflow_o, unexpected_b_o  sticky flags
//   stat_done_o, stat_tout_o     completion / timeout event counters
module wr_budget_tracker
    import wr_budget_pkg::*;
#(
    parameter int unsigned NumSlots    = DefNumSlots,
    parameter int unsigned IdWidth     = DefIdWidth,
    parameter int unsigned BudgetWidth = DefBudgetWidth,
    parameter int unsigned MaxTxnPerId = DefMaxTxnPerId,
    parameter bit          ReloadOnB   = 1'b1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [BudgetWidth-1:0] budget_i,
    input  logic                   aw_valid_i,
    input  logic                   aw_ready_i,
    input  logic [IdWidth-1:0]     aw_id_i,
    input  logic                   b_valid_i,
    input  logic                   b_ready_i,
    input  logic [IdWidth-1:0]     b_id_i,
    input  logic                   clr_i,
    output logic                   accept_o,
    output logic [NumSlots-1:0]    slot_busy_o,
    output logic [NumSlots-1:0]    timeout_o,
    output logic                   timeout_irq_o,
    output logic                   overflow_o,
    output logic                   unexpected_b_o,
    output logic [StatWidth-1:0]   stat_done_o,
    output logic [StatWidth-1:0]   stat_tout_o
);

    localparam int unsigned CntWidth = txn_cnt_width(MaxTxnPerId);

    slot_state_e         slot_state [NumSlots];
    logic [IdWidth-1:0]  slot_id    [NumSlots];
    logic [CntWidth-1:0] num_txn    [NumSlots];

    logic [NumSlots-1:0] busy, expired, aw_match, b_match, first_free;
    logic [NumSlots-1:0] alloc, inc, dec, expire_c;
    logic                aw_hs, b_hs, aw_match_any, aw_match_full, free_found, accept_c;

    logic overflow_q, overflow_d;
    logic unexp_b_q, unexp_b_d;
    logic irq_q, irq_d;
    logic expire_seen_q;

    assign aw_hs = aw_valid_i & aw_ready_i;
    assign b_hs  = b_valid_i & b_ready_i;

    // ID compare against every allocated slot.
    always_comb begin
        busy     = '0;
        expired  = '0;
        aw_match = '0;
        b_match  = '0;
        for (int i = 0; i < NumSlots; i++) begin
            busy[i]     = (slot_state[i] != SLOT_FREE);
            expired[i]  = (slot_state[i] == SLOT_EXPIRED);
            aw_match[i] = busy[i] && (slot_id[i] == aw_id_i);
            b_match[i]  = busy[i] && (slot_id[i] == b_id_i);
        end
    end

    // Lowest-index free slot and whether the matching slot is already full.
    always_comb begin
        first_free    = '0;
        free_found    = 1'b0;
        aw_match_full = 1'b0;
        for (int i = 0; i < NumSlots; i++) begin
            if (!busy[i] && !free_found) begin
                first_free[i] = 1'b1;
                free_found    = 1'b1;
            end
            if (aw_match[i] && (num_txn[i] == CntWidth'(MaxTxnPerId))) begin
                aw_match_full = 1'b1;
            end
        end
    end

    assign aw_match_any = |aw_match;
    assign accept_c     = aw_match_any ? !aw_match_full : free_found;
    assign accept_o     = accept_c;

    // Allocation uses the pre-edge free set, so a slot freed this cycle is not reused.
    assign alloc = {NumSlots{aw_hs && !aw_match_any}} & first_free;
    assign inc   = {NumSlots{aw_hs && !aw_match_full}} & aw_match;
    assign dec   = {NumSlots{b_hs}} & b_match;

    for (genvar g = 0; g < NumSlots; g++) begin : g_slot
        wr_budget_slot #(
            .IdWidth     (IdWidth),
            .BudgetWidth (BudgetWidth),
            .MaxTxnPerId (MaxTxnPerId),
            .ReloadOnB   (ReloadOnB)
        ) u_slot (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .alloc_i    (alloc[g]),
            .inc_i      (inc[g]),
            .dec_i      (dec[g]),
            .id_i       (aw_id_i),
            .budget_i   (budget_i),
            .state_o    (slot_state[g]),
            .id_o       (slot_id[g]),
            .num_txn_o  (num_txn[g]),
            .expire_c_o (expire_c[g])
        );
    end

    assign slot_busy_o = busy;
    assign timeout_o   = expired;

    // Sticky flags: clear first, then any event in the same cycle re-sets.
    always_comb begin
        overflow_d = overflow_q;
        unexp_b_d  = unexp_b_q;
        irq_d      = irq_q;
        if (clr_i) begin
            overflow_d = 1'b0;
            unexp_b_d  = 1'b0;
            irq_d      = 1'b0;
        end
        if (aw_hs && !accept_c)  overflow_d = 1'b1;
        if (b_hs && !(|b_match)) unexp_b_d  = 1'b1;
        // The irq follows the expiry edge by one cycle.
        if (expire_seen_q)       irq_d      = 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            overflow_q    <= 1'b0;
            unexp_b_q     <= 1'b0;
            irq_q         <= 1'b0;
            expire_seen_q <= 1'b0;
        end else begin
            overflow_q    <= overflow_d;
            unexp_b_q     <= unexp_b_d;
            irq_q         <= irq_d;
            expire_seen_q <= |expire_c;
        end
    end

    assign overflow_o     = overflow_q;
    assign unexpected_b_o = unexp_b_q;
    assign timeout_irq_o  = irq_q;

`ifdef WR_BUDGET_STATS_EN
    localparam int unsigned SumWidth = StatWidth + 1;

    logic [StatWidth-1:0] stat_done_q, stat_done_d, stat_tout_q, stat_tout_d;
    logic [SumWidth-1:0]  done_sum, tout_sum;

    // Saturating event counters; several slots may expire on the same edge.
    always_comb begin
        done_sum    = {1'b0, stat_done_q} + SumWidth'(b_hs && (|b_match));
        tout_sum    = {1'b0, stat_tout_q} + SumWidth'($countones(expire_c));
        stat_done_d = done_sum[StatWidth] ? '1 : done_sum[StatWidth-1:0];
        stat_tout_d = tout_sum[StatWidth] ? '1 : tout_sum[StatWidth-1:0];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stat_done_q <= '0;
            stat_tout_q <= '0;
        end else begin
            stat_done_q <= stat_done_d;
            stat_tout_q <= stat_tout_d;
        end
    end

    assign stat_done_o = stat_done_q;
    assign stat_tout_o = stat_tout_q;
`else
    assign stat_done_o = '0;
    assign stat_tout_o = '0;
`endif

endmodule

// File: tb/tb_wr_budget_tracker.sv
// Self-checking bench for wr_budget_tracker: directed vector table, hand
// sequences for timing corners, and random traffic against a reference model.
// Two instances run side by side: reload-on-B enabled and disabled.
module tb_wr_budget_tracker;

    localparam int unsigned NS = 4;
    localparam int unsigned IW = 4;
    localparam int unsigned BW = 8;
    localparam int unsigned MX = 4;
`ifdef WR_BUDGET_STATS_EN
    localparam bit StatsOn = 1'b1;
`else
    localparam bit StatsOn = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          aw_valid, aw_ready, b_valid, b_ready, clr;
    logic [IW-1:0] aw_id, b_id;
    logic [BW-1:0] budget;

    logic          acc_r, acc_n, irq_r, irq_n, ovf_r, ovf_n, ub_r, ub_n;
    logic [NS-1:0] busy_r, busy_n, tout_r, tout_n;
    logic [15:0]   sd_r, sd_n, st_r, st_n;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    wr_budget_tracker #(.NumSlots(NS), .IdWidth(IW), .BudgetWidth(BW),
                        .MaxTxnPerId(MX), .ReloadOnB(1'b1)) dut_r (
        .clk_i(clk), .rst_i(rst), .budget_i(budget),
        .aw_valid_i(aw_valid), .aw_ready_i(aw_ready), .aw_id_i(aw_id),
        .b_valid_i(b_valid), .b_ready_i(b_ready), .b_id_i(b_id), .clr_i(clr),
        .accept_o(acc_r), .slot_busy_o(busy_r), .timeout_o(tout_r),
        .timeout_irq_o(irq_r), .overflow_o(ovf_r), .unexpected_b_o(ub_r),
        .stat_done_o(sd_r), .stat_tout_o(st_r));

    wr_budget_tracker #(.NumSlots(NS), .IdWidth(IW), .BudgetWidth(BW),
                        .MaxTxnPerId(MX), .ReloadOnB(1'b0)) dut_n (
        .clk_i(clk), .rst_i(rst), .budget_i(budget),
        .aw_valid_i(aw_valid), .aw_ready_i(aw_ready), .aw_id_i(aw_id),
        .b_valid_i(b_valid), .b_ready_i(b_ready), .b_id_i(b_id), .clr_i(clr),
        .accept_o(acc_n), .slot_busy_o(busy_n), .timeout_o(tout_n),
        .timeout_irq_o(irq_n), .overflow_o(ovf_n), .unexpected_b_o(ub_n),
        .stat_done_o(sd_n), .stat_tout_o(st_n));

    typedef struct {
        logic          aw;
        logic [IW-1:0] aid;
        logic          b;
        logic [IW-1:0] bid;
        logic          clr;
        logic          acc;
        logic [NS-1:0] busy;
        logic          ovf;
        logic          ub;
    } vec_t;

    vec_t tbl[21];

    function automatic vec_t mk(input int aw, input int aid, input int b, input int bid,
                                input int c, input int acc, input int busy,
                                input int ovf, input int ub);
        vec_t v;
        v.aw   = 1'(aw);
        v.aid  = IW'(aid);
        v.b    = 1'(b);
        v.bid  = IW'(bid);
        v.clr  = 1'(c);
        v.acc  = 1'(acc);
        v.busy = NS'(busy);
        v.ovf  = 1'(ovf);
        v.ub   = 1'(ub);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        aw_valid = 1'b0; aw_ready = 1'b1; aw_id = '0;
        b_valid  = 1'b0; b_ready  = 1'b1; b_id  = '0;
        clr = 1'b0; budget = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    // ---------------- reference model (index 0: reload on B, 1: no reload) ----
    int m_alloc[2][NS];
    int m_exp  [2][NS];
    int m_id   [2][NS];
    int m_n    [2][NS];
    int m_bud  [2][NS];
    int m_irq[2], m_ovf[2], m_ub[2], m_pend[2], m_done[2], m_tout[2];

    task automatic model_reset();
        for (int v = 0; v < 2; v++) begin
            for (int s = 0; s < NS; s++) begin
                m_alloc[v][s] = 0; m_exp[v][s] = 0; m_id[v][s] = 0;
                m_n[v][s] = 0; m_bud[v][s] = 0;
            end
            m_irq[v] = 0; m_ovf[v] = 0; m_ub[v] = 0;
            m_pend[v] = 0; m_done[v] = 0; m_tout[v] = 0;
        end
    endtask

    function automatic int find(input int v, input int id);
        for (int s = 0; s < NS; s++)
            if (m_alloc[v][s] != 0 && m_id[v][s] == id) return s;
        return -1;
    endfunction

    function automatic bit model_acc(input int v, input int id);
        int s;
        s = find(v, id);
        if (s >= 0) return (m_n[v][s] < MX);
        for (int k = 0; k < NS; k++)
            if (m_alloc[v][k] == 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_step(input int v, input bit aw, input int aid, input bit b,
                              input int bid, input bit c, input int bud, input bit reload);
        int am, bm, fs, newly;
        bit acc, inc, dec;
        am = find(v, aid);
        bm = find(v, bid);
        acc = model_acc(v, aid);
        fs = -1;
        for (int s = NS - 1; s >= 0; s--) if (m_alloc[v][s] == 0) fs = s;
        newly = 0;
        for (int s = 0; s < NS; s++) begin
            if (m_alloc[v][s] == 0) begin
                if (aw && acc && am < 0 && s == fs) begin
                    m_alloc[v][s] = 1; m_exp[v][s] = 0; m_id[v][s] = aid;
                    m_n[v][s] = 1; m_bud[v][s] = bud;
                end
            end else begin
                inc = aw && acc && (am == s);
                dec = b && (bm == s);
                m_n[v][s] = m_n[v][s] + int'(inc) - int'(dec);
                if (m_n[v][s] == 0) begin
                    m_alloc[v][s] = 0; m_exp[v][s] = 0; m_bud[v][s] = 0; m_id[v][s] = 0;
                end else if (dec && reload) begin
                    m_bud[v][s] = bud; m_exp[v][s] = 0;
                end else if (m_exp[v][s] == 0) begin
                    if (m_bud[v][s] > 0) m_bud[v][s]--;
                    else if (!dec) begin m_exp[v][s] = 1; newly++; end
                end
            end
        end
        m_irq[v]  = (m_pend[v] != 0) ? 1 : (c ? 0 : m_irq[v]);
        m_pend[v] = newly;
        m_ovf[v]  = (aw && !acc) ? 1 : (c ? 0 : m_ovf[v]);
        m_ub[v]   = (b && bm < 0) ? 1 : (c ? 0 : m_ub[v]);
        if (b && bm >= 0 && m_done[v] < 65535) m_done[v]++;
        m_tout[v] = (m_tout[v] + newly > 65535) ? 65535 : m_tout[v] + newly;
    endtask

    task automatic model_check(input int v, input string tag, input logic [NS-1:0] busy,
                               input logic [NS-1:0] tout, input logic irq, input logic ovf,
                               input logic ub, input logic [15:0] sd, input logic [15:0] st);
        logic [NS-1:0] eb, et;
        for (int s = 0; s < NS; s++) begin
            eb[s] = (m_alloc[v][s] != 0);
            et[s] = (m_exp[v][s] != 0);
        end
        chk({tag, "_busy"}, 32'(busy), 32'(eb));
        chk({tag, "_tout"}, 32'(tout), 32'(et));
        chk({tag, "_irq"},  32'(irq),  32'(m_irq[v]));
        chk({tag, "_ovf"},  32'(ovf),  32'(m_ovf[v]));
        chk({tag, "_ub"},   32'(ub),   32'(m_ub[v]));
        chk({tag, "_sdone"}, 32'(sd), StatsOn ? 32'(m_done[v]) : 32'd0);
        chk({tag, "_stout"}, 32'(st), StatsOn ? 32'(m_tout[v]) : 32'd0);
    endtask

    initial begin
        // aw aid  b bid clr | acc busy   ovf ub
        tbl[0]  = mk(1, 2, 0, 0, 0,  1, 'b0001, 0, 0);
        tbl[1]  = mk(1, 2, 0, 0, 0,  1, 'b0001, 0, 0);
        tbl[2]  = mk(1, 2, 0, 0, 0,  1, 'b0001, 0, 0);
        tbl[3]  = mk(1, 2, 0, 0, 0,  1, 'b0001, 0, 0);
        tbl[4]  = mk(1, 2, 0, 0, 0,  0, 'b0001, 1, 0);
        tbl[5]  = mk(0, 2, 1, 2, 0,  0, 'b0001, 1, 0);
        tbl[6]  = mk(0, 2, 1, 2, 0,  1, 'b0001, 1, 0);
        tbl[7]  = mk(0, 2, 1, 2, 0,  1, 'b0001, 1, 0);
        tbl[8]  = mk(0, 2, 1, 2, 0,  1, 'b0000, 1, 0);
        tbl[9]  = mk(0, 0, 0, 0, 1,  1, 'b0000, 0, 0);
        tbl[10] = mk(1, 0, 0, 0, 0,  1, 'b0001, 0, 0);
        tbl[11] = mk(1, 1, 0, 0, 0,  1, 'b0011, 0, 0);
        tbl[12] = mk(1, 2, 0, 0, 0,  1, 'b0111, 0, 0);
        tbl[13] = mk(1, 3, 0, 0, 0,  1, 'b1111, 0, 0);
        tbl[14] = mk(1, 7, 0, 0, 0,  0, 'b1111, 1, 0);
        tbl[15] = mk(1, 7, 1, 1, 1,  0, 'b1101, 1, 0);
        tbl[16] = mk(1, 7, 0, 0, 0,  1, 'b1111, 1, 0);
        tbl[17] = mk(0, 7, 1, 9, 0,  1, 'b1111, 1, 1);
        tbl[18] = mk(0, 0, 0, 0, 1,  1, 'b1111, 0, 0);
        tbl[19] = mk(0, 0, 1, 9, 1,  1, 'b1111, 0, 1);
        tbl[20] = mk(0, 7, 0, 0, 0,  1, 'b1111, 0, 1);

        // Reset state
        do_reset();
        chk("rst_accept", 32'(acc_r), 32'd1);
        chk("rst_busy",   32'(busy_r), 32'd0);
        chk("rst_tout",   32'(tout_r), 32'd0);
        chk("rst_flags",  32'({irq_r, ovf_r, ub_r}), 32'd0);
        chk("rst_stats",  32'({sd_r, st_r}), 32'd0);

        // Directed table: per-ID depth limit, slot fill, overflow, stray B, clr priority
        for (int i = 0; i < 21; i++) begin
            aw_valid = tbl[i].aw;  aw_ready = 1'b1; aw_id = tbl[i].aid;
            b_valid  = tbl[i].b;   b_ready  = 1'b1; b_id  = tbl[i].bid;
            clr = tbl[i].clr; budget = 8'd20;
            #1;
            chk($sformatf("tbl%0d_accept", i), 32'(acc_r), 32'(tbl[i].acc));
            cyc();
            chk($sformatf("tbl%0d_busy", i), 32'(busy_r), 32'(tbl[i].busy));
            chk($sformatf("tbl%0d_tout", i), 32'(tout_r), 32'd0);
            chk($sformatf("tbl%0d_irq", i),  32'(irq_r),  32'd0);
            chk($sformatf("tbl%0d_ovf", i),  32'(ovf_r),  32'(tbl[i].ovf));
            chk($sformatf("tbl%0d_ub", i),   32'(ub_r),   32'(tbl[i].ub));
        end
        idle_inputs();

        // Budget 5 expiry timing and irq latency
        do_reset();
        aw_valid = 1'b1; aw_id = 4'd3; budget = 8'd5;
        #1;
        chk("exp_accept", 32'(acc_r), 32'd1);
        cyc();
        aw_valid = 1'b0;
        chk("exp_alloc_busy", 32'(busy_r), 32'b0001);
        for (int k = 1; k <= 6; k++) begin
            cyc();
            chk($sformatf("exp_edge%0d_tout", k), 32'(tout_r[0]), (k == 6) ? 32'd1 : 32'd0);
        end
        chk("exp_irq_same_edge", 32'(irq_r), 32'd0);
        cyc();
        chk("exp_irq_next", 32'(irq_r), 32'd1);
        chk("exp_busy_held", 32'(busy_r), 32'b0001);

        // Same-cycle AW+B on a single-txn slot, with and without reload
        do_reset();
        aw_valid = 1'b1; aw_id = 4'd4; budget = 8'd10;
        cyc();
        aw_valid = 1'b0;
        cyc();
        cyc();
        aw_valid = 1'b1; aw_id = 4'd4; b_valid = 1'b1; b_id = 4'd4; budget = 8'd3;
        #1;
        chk("awb_accept", 32'(acc_r), 32'd1);
        cyc();
        idle_inputs();
        chk("awb_busy_r", 32'(busy_r), 32'b0001);
        chk("awb_busy_n", 32'(busy_n), 32'b0001);
        for (int k = 1; k <= 8; k++) begin
            cyc();
            chk($sformatf("awb_r_k%0d", k), 32'(tout_r[0]), (k >= 4) ? 32'd1 : 32'd0);
            chk($sformatf("awb_n_k%0d", k), 32'(tout_n[0]), (k >= 8) ? 32'd1 : 32'd0);
        end
        chk("awb_busy_end", 32'({busy_r[0], busy_n[0]}), 32'b11);

        // Statistics: 3 completions, 1 timeout, then async reset mid-operation
        do_reset();
        aw_valid = 1'b1; aw_id = 4'd1; budget = 8'd30;
        cyc();
        aw_valid = 1'b0; b_valid = 1'b1; b_id = 4'd1;
        cyc();
        b_valid = 1'b0; aw_valid = 1'b1;
        cyc();
        cyc();
        aw_valid = 1'b0; b_valid = 1'b1;
        cyc();
        cyc();
        b_valid = 1'b0;
        chk("st_drained", 32'(busy_r), 32'd0);
        aw_valid = 1'b1; aw_id = 4'd5; budget = 8'd0;
        cyc();
        aw_valid = 1'b0;
        cyc();
        chk("st_zero_budget_tout", 32'(tout_r), 32'b0001);
        chk("st_done", 32'(sd_r), StatsOn ? 32'd3 : 32'd0);
        chk("st_tout", 32'(st_r), StatsOn ? 32'd1 : 32'd0);
        cyc();
        chk("st_irq_before_rst", 32'(irq_r), 32'd1);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_busy",  32'(busy_r), 32'd0);
        chk("arst_tout",  32'(tout_r), 32'd0);
        chk("arst_flags", 32'({irq_r, ovf_r, ub_r}), 32'd0);
        chk("arst_stats", 32'({sd_r, st_r}), 32'd0);
        chk("arst_accept", 32'(acc_r), 32'd1);

        // Random traffic against the reference model
        do_reset();
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            aw_valid = ($urandom_range(0, 99) < 55);
            aw_ready = ($urandom_range(0, 99) < 75);
            aw_id    = IW'($urandom_range(0, 5));
            b_valid  = ($urandom_range(0, 99) < 55);
            b_ready  = ($urandom_range(0, 99) < 75);
            b_id     = IW'($urandom_range(0, 5));
            clr      = ($urandom_range(0, 99) < 8);
            budget   = BW'($urandom_range(0, 12));
            #1;
            chk("rnd_accept_r", 32'(acc_r), 32'(model_acc(0, int'(aw_id))));
            chk("rnd_accept_n", 32'(acc_n), 32'(model_acc(1, int'(aw_id))));
            model_step(0, aw_valid && aw_ready, int'(aw_id), b_valid && b_ready,
                       int'(b_id), clr, int'(budget), 1'b1);
            model_step(1, aw_valid && aw_ready, int'(aw_id), b_valid && b_ready,
                       int'(b_id), clr, int'(budget), 1'b0);
            cyc();
            model_check(0, "rnd_r", busy_r, tout_r, irq_r, ovf_r, ub_r, sd_r, st_r);
            model_check(1, "rnd_n", busy_n, tout_n, irq_n, ovf_n, ub_n, sd_n, st_n);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
